// File: rtl/frv_mem_port_arbiter.sv
// Shares one memory bus port between fetch (I) and load/store (D) with an in-order owner-ID FIFO.
// Define FRV_MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority D over I.
module frv_mem_port_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        g_clk,
    input  logic        g_resetn,

    input  logic        i_req,
    input  logic        i_wen,
    input  logic [3:0]  i_strb,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_recv,
    input  logic        i_ack,
    output logic        i_error,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_wen,
    input  logic [3:0]  d_strb,
    input  logic [31:0] d_wdata,
    input  logic [31:0] d_addr,
    output logic        d_gnt,
    output logic        d_recv,
    input  logic        d_ack,
    output logic        d_error,
    output logic [31:0] d_rdata,

    output logic        m_req,
    output logic        m_wen,
    output logic [3:0]  m_strb,
    output logic [31:0] m_wdata,
    output logic [31:0] m_addr,
    input  logic        m_gnt,
    input  logic        m_recv,
    input  logic        m_error,
    input  logic [31:0] m_rdata,
    output logic        m_ack
);

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    owner_e             ids_q [MAX_OUTSTANDING];
    owner_e             ids_d [MAX_OUTSTANDING];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lock_q, lock_d;
    owner_e             lock_own_q, lock_own_d;

    owner_e             head;
    owner_e             arb;
    owner_e             sel;
    logic               fifo_empty;
    logic               fifo_full;
    logic               head_ack;
    logic               resp_ok;
    logic               pop;
    logic               push;
    logic               sel_req;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

`ifdef FRV_MEM_ARB_ROUND_ROBIN_EN
    owner_e rr_q, rr_d;

    always_comb begin
        rr_d = rr_q;
        if (push) rr_d = sel;
        if (d_req && i_req) arb = (rr_q == OWN_I) ? OWN_D : OWN_I;
        else                arb = d_req ? OWN_D : OWN_I;
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) rr_q <= OWN_I;
        else           rr_q <= rr_d;
    end
`else
    always_comb begin
        arb = d_req ? OWN_D : OWN_I;
    end
`endif

    // Response side: route by FIFO head; nothing is routed while empty or in reset.
    always_comb begin
        head       = ids_q[rptr_q];
        fifo_empty = (cnt_q == '0);
        fifo_full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
        head_ack   = (head == OWN_D) ? d_ack : i_ack;
        resp_ok    = g_resetn && m_recv && !fifo_empty;
        m_ack      = g_resetn && !fifo_empty && head_ack;
        pop        = resp_ok && head_ack;

        i_recv     = resp_ok && (head == OWN_I);
        d_recv     = resp_ok && (head == OWN_D);
        i_error    = i_recv && m_error;
        d_error    = d_recv && m_error;
        i_rdata    = i_recv ? m_rdata : '0;
        d_rdata    = d_recv ? m_rdata : '0;
    end

    // Request side: a same-cycle pop frees a slot, so a full FIFO can still accept.
    always_comb begin
        sel     = lock_q ? lock_own_q : arb;
        sel_req = (sel == OWN_D) ? d_req : i_req;
        m_req   = g_resetn && sel_req && (!fifo_full || pop);
        push    = m_req && m_gnt;
        i_gnt   = push && (sel == OWN_I);
        d_gnt   = push && (sel == OWN_D);

        m_wen   = '0;
        m_strb  = '0;
        m_wdata = '0;
        m_addr  = '0;
        if (g_resetn) begin
            m_wen   = (sel == OWN_D) ? d_wen   : i_wen;
            m_strb  = (sel == OWN_D) ? d_strb  : i_strb;
            m_wdata = (sel == OWN_D) ? d_wdata : i_wdata;
            m_addr  = (sel == OWN_D) ? d_addr  : i_addr;
        end
    end

    always_comb begin
        ids_d      = ids_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        lock_d     = lock_q;
        lock_own_d = lock_own_q;

        if (push) begin
            ids_d[wptr_q] = sel;
            wptr_d        = ptr_inc(wptr_q);
        end
        if (pop) rptr_d = ptr_inc(rptr_q);

        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        if (push) begin
            lock_d = 1'b0;
        end else if (m_req) begin
            lock_d     = 1'b1;
            lock_own_d = sel;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            for (int unsigned k = 0; k < MAX_OUTSTANDING; k++) ids_q[k] <= OWN_I;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            lock_q     <= 1'b0;
            lock_own_q <= OWN_I;
        end else begin
            ids_q      <= ids_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            lock_q     <= lock_d;
            lock_own_q <= lock_own_d;
        end
    end

`ifndef SYNTHESIS
    resp_without_request: assert property (@(posedge g_clk) disable iff (!g_resetn)
        !(m_recv && fifo_empty));
`endif

endmodule

// File: tb/tb_frv_mem_port_arbiter.sv
// Directed bench for frv_mem_port_arbiter: queue-based reference model checked every cycle plus literal pins.
module tb_frv_mem_port_arbiter;

    localparam int MAX = 4;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        i_req, i_wen, i_ack, d_req, d_wen, d_ack;
    logic [3:0]  i_strb, d_strb;
    logic [31:0] i_wdata, i_addr, d_wdata, d_addr;
    logic        i_gnt, i_recv, i_error, d_gnt, d_recv, d_error;
    logic [31:0] i_rdata, d_rdata;
    logic        m_req, m_wen, m_gnt, m_recv, m_error, m_ack;
    logic [3:0]  m_strb;
    logic [31:0] m_wdata, m_addr, m_rdata;

    int errors = 0;
    int checks = 0;

    int mq[$];
    bit lock_m;
    int lock_own_m;
    int last_m;

    frv_mem_port_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .i_req(i_req), .i_wen(i_wen), .i_strb(i_strb), .i_wdata(i_wdata), .i_addr(i_addr),
        .i_gnt(i_gnt), .i_recv(i_recv), .i_ack(i_ack), .i_error(i_error), .i_rdata(i_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_strb(d_strb), .d_wdata(d_wdata), .d_addr(d_addr),
        .d_gnt(d_gnt), .d_recv(d_recv), .d_ack(d_ack), .d_error(d_error), .d_rdata(d_rdata),
        .m_req(m_req), .m_wen(m_wen), .m_strb(m_strb), .m_wdata(m_wdata), .m_addr(m_addr),
        .m_gnt(m_gnt), .m_recv(m_recv), .m_error(m_error), .m_rdata(m_rdata), .m_ack(m_ack)
    );

    always #5 g_clk = ~g_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: owner queue, lock and last-granted ID; evaluated mid-cycle once inputs are stable.
    always @(negedge g_clk) begin : model
        bit empty, full, pop, gnt, e_ack, e_mreq, e_ir, e_dr;
        int head, own;
        if (!g_resetn) begin
            chk("rst_m_req", m_req, 0);     chk("rst_m_ack", m_ack, 0);
            chk("rst_i_gnt", i_gnt, 0);     chk("rst_d_gnt", d_gnt, 0);
            chk("rst_i_recv", i_recv, 0);   chk("rst_d_recv", d_recv, 0);
            chk("rst_i_error", i_error, 0); chk("rst_d_error", d_error, 0);
            chk("rst_i_rdata", i_rdata, 0); chk("rst_d_rdata", d_rdata, 0);
            chk("rst_m_wen", m_wen, 0);     chk("rst_m_strb", m_strb, 0);
            chk("rst_m_wdata", m_wdata, 0); chk("rst_m_addr", m_addr, 0);
            mq.delete();
            lock_m = 0;
            lock_own_m = 0;
            last_m = 0;
        end else begin
            empty = (mq.size() == 0);
            head  = empty ? 0 : mq[0];
            e_ack = !empty && ((head == 1) ? d_ack : i_ack);
            e_ir  = m_recv && !empty && head == 0;
            e_dr  = m_recv && !empty && head == 1;
            pop   = m_recv && e_ack;
            if (lock_m) own = lock_own_m;
`ifdef FRV_MEM_ARB_ROUND_ROBIN_EN
            else if (d_req && i_req) own = (last_m == 0) ? 1 : 0;
`else
            else if (d_req && i_req) own = 1;
`endif
            else own = d_req ? 1 : 0;
            full   = (mq.size() == MAX);
            e_mreq = ((own == 1) ? d_req : i_req) && (!full || pop);
            gnt    = e_mreq && m_gnt;

            chk("m_req", m_req, e_mreq);
            chk("m_ack", m_ack, e_ack);
            chk("i_gnt", i_gnt, gnt && own == 0);
            chk("d_gnt", d_gnt, gnt && own == 1);
            chk("i_recv", i_recv, e_ir);
            chk("d_recv", d_recv, e_dr);
            if (e_mreq) begin
                chk("m_wen", m_wen, (own == 1) ? d_wen : i_wen);
                chk("m_strb", m_strb, (own == 1) ? d_strb : i_strb);
                chk("m_wdata", m_wdata, (own == 1) ? d_wdata : i_wdata);
                chk("m_addr", m_addr, (own == 1) ? d_addr : i_addr);
            end
            if (e_ir) begin
                chk("i_rdata", i_rdata, m_rdata);
                chk("i_error", i_error, m_error);
            end
            if (e_dr) begin
                chk("d_rdata", d_rdata, m_rdata);
                chk("d_error", d_error, m_error);
            end

            if (pop) void'(mq.pop_front());
            if (gnt) begin
                mq.push_back(own);
                last_m = own;
                lock_m = 0;
            end else if (e_mreq) begin
                lock_m = 1;
                lock_own_m = own;
            end
        end
    end

    task automatic settle();
        @(negedge g_clk);
        #1;
    endtask

    task automatic next();
        @(posedge g_clk);
        #1;
    endtask

    task automatic drain(input int n);
        i_req = 0; d_req = 0; m_gnt = 0;
        m_recv = 1; i_ack = 1; d_ack = 1;
        for (int k = 0; k < n; k++) next();
        m_recv = 0; i_ack = 0; d_ack = 0;
    endtask

    initial begin
        g_resetn = 0;
        i_req = 0; i_wen = 0; i_strb = 4'h0; i_wdata = 32'h0; i_addr = 32'h0; i_ack = 0;
        d_req = 0; d_wen = 1; d_strb = 4'h3; d_wdata = 32'hCAFE_0001; d_addr = 32'hD000_0000; d_ack = 0;
        m_gnt = 0; m_recv = 0; m_error = 0; m_rdata = 32'h0;
        next(); next();
        g_resetn = 1;

        // 1: single I request and its response
        i_req = 1; i_addr = 32'h8000_0000; m_gnt = 1;
        settle();
        chk("t1_i_gnt", i_gnt, 1);
        chk("t1_d_gnt", d_gnt, 0);
        chk("t1_m_addr", m_addr, 32'h8000_0000);
        chk("t1_model_head", (mq.size() == 1 && mq[0] == 0) ? 1 : 0, 1);
        next();
        i_req = 0; m_gnt = 0; m_recv = 1; m_rdata = 32'h1234_5678; i_ack = 1;
        settle();
        chk("t1_i_recv", i_recv, 1);
        chk("t1_d_recv", d_recv, 0);
        chk("t1_i_rdata", i_rdata, 32'h1234_5678);
        chk("t1_model_empty", mq.size(), 0);
        next();
        m_recv = 0; i_ack = 0;

        // 2: simultaneous requests
        i_req = 1; i_addr = 32'h8000_0010; d_req = 1; d_addr = 32'hD000_0020; m_gnt = 1;
        settle();
        chk("t2_d_gnt", d_gnt, 1);
        chk("t2_i_gnt", i_gnt, 0);
        chk("t2_m_addr", m_addr, 32'hD000_0020);
        next();
        d_req = 0;
        settle();
        chk("t2_i_gnt_next", i_gnt, 1);
        next();
        drain(2);
        i_req = 1; d_req = 1; m_gnt = 1;
        for (int k = 0; k < 4; k++) begin
            settle();
`ifdef FRV_MEM_ARB_ROUND_ROBIN_EN
            chk("t2_rr_d_gnt", d_gnt, (k % 2 == 0) ? 1 : 0);
            chk("t2_rr_i_gnt", i_gnt, (k % 2 == 1) ? 1 : 0);
`else
            chk("t2_fp_d_gnt", d_gnt, 1);
            chk("t2_fp_i_gnt", i_gnt, 0);
`endif
            next();
        end
        drain(4);

        // 3: pending D request keeps the bus while I arrives
        d_req = 1; d_addr = 32'hD000_0030; m_gnt = 0;
        for (int k = 0; k < 5; k++) begin
            if (k == 3) begin i_req = 1; i_addr = 32'h8000_0100; end
            settle();
            chk("t3_m_addr", m_addr, 32'hD000_0030);
            chk("t3_i_gnt", i_gnt, 0);
            chk("t3_m_req", m_req, 1);
            next();
        end
        m_gnt = 1;
        settle();
        chk("t3_d_gnt", d_gnt, 1);
        next();
        d_req = 0;
        settle();
        chk("t3_i_gnt_after", i_gnt, 1);
        next();
        drain(2);

        // 4: FIFO full blocks, pop plus push keeps count
        i_req = 1; i_addr = 32'h8000_0200; m_gnt = 1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("t4_i_gnt", i_gnt, 1);
            next();
        end
        settle();
        chk("t4_full_m_req", m_req, 0);
        chk("t4_full_i_gnt", i_gnt, 0);
        chk("t4_model_count", mq.size(), 4);
        next();
        m_recv = 1; i_ack = 1; m_rdata = 32'h0000_0044;
        settle();
        chk("t4_pp_i_gnt", i_gnt, 1);
        chk("t4_pp_m_ack", m_ack, 1);
        chk("t4_pp_i_recv", i_recv, 1);
        chk("t4_pp_model_count", mq.size(), 4);
        next();
        m_recv = 0; i_ack = 0;
        drain(4);

        // 5: interleaved I,D,I with stalled D ack and error
        m_gnt = 1;
        i_req = 1; next();
        i_req = 0; d_req = 1; next();
        d_req = 0; i_req = 1; next();
        i_req = 0; m_gnt = 0;
        m_recv = 1; m_rdata = 32'h0000_00A1; m_error = 0; i_ack = 1; d_ack = 0;
        settle();
        chk("t5_i_recv_1", i_recv, 1);
        chk("t5_i_rdata_1", i_rdata, 32'h0000_00A1);
        next();
        m_rdata = 32'h0000_00B2; m_error = 1;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("t5_d_recv_stall", d_recv, 1);
            chk("t5_m_ack_stall", m_ack, 0);
            chk("t5_i_recv_stall", i_recv, 0);
            chk("t5_d_error", d_error, 1);
            next();
        end
        d_ack = 1;
        settle();
        chk("t5_m_ack_d", m_ack, 1);
        chk("t5_d_rdata", d_rdata, 32'h0000_00B2);
        next();
        m_rdata = 32'h0000_00C3; m_error = 0;
        settle();
        chk("t5_i_recv_3", i_recv, 1);
        chk("t5_i_error_3", i_error, 0);
        chk("t5_model_empty", mq.size(), 0);
        next();
        m_recv = 0; i_ack = 0; d_ack = 0;

        // 6: reset with outstanding requests
        i_req = 1; m_gnt = 1;
        for (int k = 0; k < 3; k++) next();
        g_resetn = 0;
        settle();
        chk("t6_rst_m_req", m_req, 0);
        chk("t6_rst_i_gnt", i_gnt, 0);
        next();
        i_req = 0; m_gnt = 0; m_recv = 1; i_ack = 1; d_ack = 1; m_rdata = 32'hDEAD_BEEF;
        settle();
        chk("t6_drop_m_ack", m_ack, 0);
        chk("t6_drop_i_recv", i_recv, 0);
        chk("t6_drop_d_recv", d_recv, 0);
        chk("t6_model_empty", mq.size(), 0);
        next();
        m_recv = 0;
        g_resetn = 1;
        settle();
        chk("t6_post_m_ack", m_ack, 0);
        chk("t6_post_m_req", m_req, 0);
        next();
        i_ack = 0; d_ack = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
